csc_stream_ctrl: RTL

Sequencing controller for the RGB→YCbCr colour-space converter at the front of the encoder input path. It accepts a raster-order RGB pixel stream over a valid/ready handshake and issues pixels to the fixed-latency, non-backpressurable converter. It tracks converter results in flight with a tag pipeline and buffers them in an internal FIFO. It presents frame-tagged YCbCr pixels downstream over valid/ready, with credit-based flow control so no converter result is ever dropped.

---
 rtl/csc_stream_ctrl.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/csc_stream_ctrl.sv
// csc_stream_ctrl: sequences a raster RGB stream through the fixed-latency
// colour-space converter, tags results in flight and buffers them for a
// credit-protected valid/ready YCbCr output.
module csc_stream_ctrl #(
    parameter int unsigned FRAME_W    = 320,
    parameter int unsigned FRAME_H    = 240,
    parameter int unsigned CSC_LAT    = 2,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic        busy,
    output logic        done,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [23:0] s_rgb,
    output logic        csc_valid_in,
    output logic [8:0]  csc_r,
    output logic [8:0]  csc_g,
    output logic [8:0]  csc_b,
    input  logic        csc_valid_out,
    input  logic [23:0] csc_pixel,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [23:0] m_pixel,
    output logic        m_sof,
    output logic        m_eol,
    output logic        m_eof,
    output logic        err_tag
);

    localparam int unsigned XW = (FRAME_W > 1) ? $clog2(FRAME_W) : 1;
    localparam int unsigned YW = (FRAME_H > 1) ? $clog2(FRAME_H) : 1;
    localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned EW = 27;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t          state;
    logic [XW-1:0]   x;
    logic [YW-1:0]   y;
    logic [2:0]      issue_flags;
    logic [3:0]      tag_pipe [CSC_LAT];
    logic [EW-1:0]   mem [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   fifo_count;
    logic [CW-1:0]   inflight;
    logic [CW-1:0]   fifo_next;
    logic [CW-1:0]   infl_next;
    logic [3:0]      tag_out;
    logic [EW-1:0]   head;
    logic            accept;
    logic            push;
    logic            pop;
    logic            x_last;
    logic            y_last;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Handshake and FIFO head decode, all from registered state
    assign tag_out = tag_pipe[CSC_LAT-1];
    assign push    = tag_out[3];
    assign s_ready = (state == RUN) && ((32'(fifo_count) + 32'(inflight)) < FIFO_DEPTH);
    assign accept  = s_valid && s_ready;
    assign m_valid = (fifo_count != '0);
    assign pop     = m_valid && m_ready;
    assign head    = mem[rd_ptr];
    assign m_pixel = head[26:3];
    assign m_sof   = head[2];
    assign m_eol   = head[1];
    assign m_eof   = head[0];
    assign x_last  = (x == XW'(FRAME_W - 1));
    assign y_last  = (y == YW'(FRAME_H - 1));

    // Next-cycle occupancy; lets DONE follow the final pop without a bubble
    always_comb begin
        fifo_next = fifo_count;
        infl_next = inflight;
        if (push && !pop) fifo_next = fifo_count + CW'(1);
        if (pop && !push) fifo_next = fifo_count - CW'(1);
        if (accept && !push) infl_next = inflight + CW'(1);
        if (push && !accept) infl_next = inflight - CW'(1);
    end

    // Frame FSM with raster position counters and registered status
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            x     <= '0;
            y     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= RUN;
                        busy  <= 1'b1;
                        x     <= '0;
                        y     <= '0;
                    end
                end
                RUN: begin
                    if (accept) begin
                        if (x_last) begin
                            x <= '0;
                            y <= y_last ? '0 : y + YW'(1);
                        end else begin
                            x <= x + XW'(1);
                        end
                        if (x_last && y_last) state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (fifo_next == '0 && infl_next == '0) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Converter issue, tag pipeline, result FIFO and occupancy counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            csc_valid_in <= 1'b0;
            csc_r        <= '0;
            csc_g        <= '0;
            csc_b        <= '0;
            issue_flags  <= '0;
            err_tag      <= 1'b0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fifo_count   <= '0;
            inflight     <= '0;
            for (int unsigned i = 0; i < CSC_LAT; i++) tag_pipe[i] <= '0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
        end else begin
            csc_valid_in <= accept;
            if (accept) begin
                csc_r       <= {1'b0, s_rgb[23:16]};
                csc_g       <= {1'b0, s_rgb[15:8]};
                csc_b       <= {1'b0, s_rgb[7:0]};
                issue_flags <= {(x == '0) && (y == '0), x_last, x_last && y_last};
            end
            // Issue register acts as the first tag slot, so the last stage meets the result
            tag_pipe[0] <= {csc_valid_in, issue_flags};
            for (int unsigned i = 1; i < CSC_LAT; i++) tag_pipe[i] <= tag_pipe[i-1];
            err_tag <= tag_out[3] ^ csc_valid_out;
            if (push) begin
                mem[wr_ptr] <= {csc_pixel, tag_out[2:0]};
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (pop) rd_ptr <= ptr_inc(rd_ptr);
            fifo_count <= fifo_next;
            inflight   <= infl_next;
        end
    end

endmodule
